// File: rtl/fsm_cnt_run.sv
// ---------------------------------------------------------------------------
// fsm_cnt_run
//
// Purpose:
//   Run/done controller for a datapath that needs a "busy for N cycles"
//   enable. A start request in IDLE latches a job length N and starts the
//   job. RUN lasts exactly N cycles, and then DONE pulses for one cycle.
//   From DONE the job either repeats with the same N or the controller
//   returns to IDLE. An abort in RUN drops straight back to IDLE without a
//   done pulse. A zero-length job goes directly to DONE.
//
// Ports:
//   clk        in   1          system clock, rising edge
//   reset_n    in   1          synchronous active-low reset
//   i_run      in   1          start request, only looked at in IDLE
//   i_num_cnt  in   CNT_WIDTH  job length N, latched when the start is taken
//   i_abort    in   1          abandon the job, only looked at in RUN
//   i_repeat   in   1          looked at in DONE: 1 = rerun same N, 0 = idle
//   o_idle     out  1          high while in IDLE
//   o_running  out  1          high while in RUN
//   o_done     out  1          high for the DONE cycle
//   o_cnt      out  CNT_WIDTH  cycle index inside the job, 0 outside RUN
//   c_state    out  2          current state encoding, for observation
// ---------------------------------------------------------------------------
module fsm_cnt_run #(
  parameter int CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_run,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  input  logic                 i_abort,
  input  logic                 i_repeat,
  output logic                 o_idle,
  output logic                 o_running,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic [1:0]           c_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               state;
  state_t               next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] next_cnt;
  logic [CNT_WIDTH-1:0] num_lat;
  logic [CNT_WIDTH-1:0] next_num;
  logic [CNT_WIDTH-1:0] last_idx;

  // Index of the final RUN cycle. RUN is only entered with a non-zero N,
  // so this subtraction never underflows where it is used. Stopping on
  // this index also means the counter never wraps, even at the largest N.
  assign last_idx = num_lat - ONE;

  // Next-state and next-counter logic. Abort is tested before the
  // terminal compare, so an abort on the last RUN cycle still suppresses
  // done. The counter is zeroed on every exit from RUN so that each job
  // starts from index 0.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_num   = num_lat;
    case (state)
      S_IDLE: begin
        if (i_run) begin
          next_num   = i_num_cnt;
          next_cnt   = '0;
          next_state = (i_num_cnt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          next_state = S_IDLE;
          next_cnt   = '0;
        end else if (cnt == last_idx) begin
          next_state = S_DONE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + ONE;
        end
      end
      S_DONE: begin
        next_cnt = '0;
        if (i_repeat) begin
          // A latched zero-length job repeats as back-to-back DONE cycles.
          next_state = (num_lat == '0) ? S_DONE : S_RUN;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // State, counter, latched length and status outputs are all registered
  // together. The outputs are decoded from the next state, so they line up
  // with the state register on the same edge, and no input can reach an
  // output without passing through a flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      num_lat   <= '0;
      o_idle    <= 1'b1;
      o_running <= 1'b0;
      o_done    <= 1'b0;
      o_cnt     <= '0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      num_lat   <= next_num;
      o_idle    <= (next_state == S_IDLE);
      o_running <= (next_state == S_RUN);
      o_done    <= (next_state == S_DONE);
      o_cnt     <= (next_state == S_RUN) ? next_cnt : '0;
    end
  end

  assign c_state = state;

endmodule

// File: tb/tb_fsm_cnt_run.sv
// ---------------------------------------------------------------------------
// tb_fsm_cnt_run
//
// Purpose:
//   Self-checking bench for fsm_cnt_run, built with CNT_WIDTH=4 so that the
//   full-length job (N=15) stays short. A job-level reference model tracks
//   only whether a job is active, the cycle on which it started and its
//   length. From these it derives the expected running/done/cnt values
//   with plain arithmetic on cycle numbers. Directed sequences come first,
//   followed by a random run.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_fsm_cnt_run;

  localparam int W = 4;

  logic         clk;
  logic         reset_n;
  logic         i_run;
  logic [W-1:0] i_num_cnt;
  logic         i_abort;
  logic         i_repeat;
  logic         o_idle;
  logic         o_running;
  logic         o_done;
  logic [W-1:0] o_cnt;
  logic [1:0]   c_state;

  int total;
  int bad;

  // Job-level reference model state
  int  cyc;
  bit  job_active;
  int  job_start;
  int  job_len;

  fsm_cnt_run #(.CNT_WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (i_run),
    .i_num_cnt (i_num_cnt),
    .i_abort   (i_abort),
    .i_repeat  (i_repeat),
    .o_idle    (o_idle),
    .o_running (o_running),
    .o_done    (o_done),
    .o_cnt     (o_cnt),
    .c_state   (c_state)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count it and report it if it differs
  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, observed, expected);
    end
  endtask

  // Phase helpers, derived from elapsed cycles since the job started
  function automatic bit expRunning();
    return job_active && ((cyc - job_start) < job_len);
  endfunction

  function automatic bit expDone();
    return job_active && ((cyc - job_start) == job_len);
  endfunction

  function automatic int expCnt();
    return expRunning() ? (cyc - job_start) : 0;
  endfunction

  // Advance the model across one clock edge using the inputs now driven
  task automatic modelEdge();
    if (!reset_n) begin
      job_active = 1'b0;
      job_len    = 0;
    end else if (!job_active) begin
      if (i_run) begin
        job_active = 1'b1;
        job_start  = cyc + 1;
        job_len    = int'(i_num_cnt);
      end
    end else if (expRunning()) begin
      if (i_abort) job_active = 1'b0;
    end else if (expDone()) begin
      if (i_repeat) job_start = cyc + 1;
      else          job_active = 1'b0;
    end
    cyc++;
  endtask

  task automatic compareAll();
    int es;
    es = !job_active ? 0 : (expRunning() ? 1 : 2);
    checkOutput("o_idle",    int'(o_idle),    int'(!job_active));
    checkOutput("o_running", int'(o_running), int'(expRunning()));
    checkOutput("o_done",    int'(o_done),    int'(expDone()));
    checkOutput("o_cnt",     int'(o_cnt),     expCnt());
    checkOutput("c_state",   int'(c_state),   es);
  endtask

  // Drive one cycle of inputs, clock it, then check 1 time unit later
  task automatic applyStimulus(input bit rn, input bit run, input int num,
                               input bit ab, input bit rep);
    reset_n   = rn;
    i_run     = run;
    i_num_cnt = num[W-1:0];
    i_abort   = ab;
    i_repeat  = rep;
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    job_active = 1'b0;
    job_start  = 0;
    job_len    = 0;
    reset_n    = 1'b0;
    i_run      = 1'b0;
    i_num_cnt  = '0;
    i_abort    = 1'b0;
    i_repeat   = 1'b0;
    #2;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 1, 1);
    idleCycles(2);

    // Basic job of length 5
    applyStimulus(1, 1, 5, 0, 0);
    idleCycles(8);

    // Zero-length job goes straight to done
    applyStimulus(1, 1, 0, 0, 0);
    idleCycles(3);

    // N=10: new start requests during RUN are ignored, abort at index 3
    applyStimulus(1, 1, 10, 0, 0);
    for (int k = 0; k < 12 && job_active; k++) begin
      if (expRunning() && expCnt() == 3) applyStimulus(1, 1, 2, 1, 0);
      else                               applyStimulus(1, 1, 2, 0, 0);
    end
    idleCycles(3);

    // Abort on the last RUN cycle must still suppress done
    applyStimulus(1, 1, 4, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    idleCycles(2);

    // Repeat mode with N=3, then release repeat
    applyStimulus(1, 1, 3, 0, 1);
    for (int k = 0; k < 12; k++) applyStimulus(1, 0, 9, 0, 1);
    for (int k = 0; k < 6; k++)  applyStimulus(1, 0, 0, 0, 0);

    // Repeat with a latched zero length keeps done high
    applyStimulus(1, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 1);
    idleCycles(2);

    // Full-length job, no wrap of the counter
    applyStimulus(1, 1, 15, 0, 0);
    idleCycles(18);

    // Reset in the middle of a full-length job
    applyStimulus(1, 1, 15, 0, 0);
    for (int k = 0; k < 20 && !(expRunning() && expCnt() == 7); k++)
      applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    idleCycles(3);

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      bit rn, run, ab, rep;
      int num;
      rn  = ($urandom_range(0, 63) != 0);
      run = ($urandom_range(0, 3) == 0);
      ab  = ($urandom_range(0, 15) == 0);
      rep = ($urandom_range(0, 2) == 0);
      num = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                        : int'($urandom_range(0, 4));
      applyStimulus(rn, run, num, ab, rep);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
